// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The MDOp_* codes sit next to the ALUOp_* codes used by the execute stage.
package muldiv_pkg;

   localparam logic [1:0] MDOp_MULT  = 2'b00;
   localparam logic [1:0] MDOp_MULTU = 2'b01;
   localparam logic [1:0] MDOp_DIV   = 2'b10;
   localparam logic [1:0] MDOp_DIVU  = 2'b11;

   // Bit 0 clear selects the signed flavour of both multiply and divide.
   function automatic logic md_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic md_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// One result bit per cycle through a single shared adder/subtractor; signs fixed up at the end.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             hi_we,
   input  logic             lo_we,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  acc_q, acc_d;
   logic [WIDTH-1:0]  sh_q, sh_d;
   logic [WIDTH-1:0]  opnd_q, opnd_d;
   logic [1:0]        op_q, op_d;
   logic              neg_q, neg_d;
   logic              sgn_a_q, sgn_a_d;
   logic              div0_q, div0_d;
   logic [WIDTH-1:0]  hi_q, hi_d;
   logic [WIDTH-1:0]  lo_q, lo_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [WIDTH:0]    add_x, add_y;
   logic              add_ci;
   logic [WIDTH+1:0]  add_res;
   logic              a_neg, b_neg;
   logic [WIDTH-1:0]  a_mag, b_mag;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]  quo, rem;

   // Shared adder: shift-add for multiply, trial subtraction for restoring divide.
   always_comb begin
      if (md_is_div(op_q)) begin
         add_x  = {acc_q, sh_q[WIDTH-1]};
         add_y  = ~{1'b0, opnd_q};
         add_ci = 1'b1;
      end else begin
         add_x  = {1'b0, acc_q};
         add_y  = sh_q[0] ? {1'b0, opnd_q} : '0;
         add_ci = 1'b0;
      end
      add_res = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_ci};
   end

   always_comb begin
      a_neg = md_is_signed(op) & A[WIDTH-1];
      b_neg = md_is_signed(op) & B[WIDTH-1];
      a_mag = a_neg ? -A : A;
      b_mag = b_neg ? -B : B;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      sh_d    = sh_q;
      opnd_d  = opnd_q;
      op_d    = op_q;
      neg_d   = neg_q;
      sgn_a_d = sgn_a_q;
      div0_d  = div0_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      prod    = {acc_q, sh_q};
      quo     = sh_q;
      rem     = acc_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               op_d    = op;
               neg_d   = a_neg ^ b_neg;
               sgn_a_d = a_neg;
               div0_d  = (B == '0);
               acc_d   = '0;
               cnt_d   = CntW'(WIDTH - 1);
               sh_d    = md_is_div(op) ? a_mag : b_mag;
               opnd_d  = md_is_div(op) ? b_mag : a_mag;
               state_d = StCalc;
            end else begin
               if (hi_we) hi_d = A;
               if (lo_we) lo_d = A;
            end
         end
         StCalc: begin
            if (md_is_div(op_q)) begin
               // Carry out of the trial subtraction means the divisor fits.
               acc_d = add_res[WIDTH+1] ? add_res[WIDTH-1:0] : add_x[WIDTH-1:0];
               sh_d  = {sh_q[WIDTH-2:0], add_res[WIDTH+1]};
            end else begin
               acc_d = add_res[WIDTH:1];
               sh_d  = {add_res[0], sh_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == '0) state_d = StFix;
         end
         StFix: begin
            if (md_is_div(op_q)) begin
               // Divide by zero keeps the all-ones quotient; restoring the dividend
               // sign on the remainder gives back A exactly.
               if (md_is_signed(op_q) && neg_q && !div0_q) quo = -sh_q;
               if (md_is_signed(op_q) && sgn_a_q) rem = -acc_q;
               lo_d = quo;
               hi_d = rem;
            end else begin
               if (md_is_signed(op_q) && neg_q) prod = -{acc_q, sh_q};
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acc_q   <= '0;
         sh_q    <= '0;
         opnd_q  <= '0;
         op_q    <= '0;
         neg_q   <= 1'b0;
         sgn_a_q <= 1'b0;
         div0_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         sh_q    <= sh_d;
         opnd_q  <= opnd_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         sgn_a_q <= sgn_a_d;
         div0_q  <= div0_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
